// File: rtl/pong_pkg.sv
// Shared constants, types and helpers for the pong renderer: screen and sprite
// geometry, colours, score-glyph layout and the seven-segment table.
package pong_pkg;

    localparam int H_VIDEO    = 640;
    localparam int V_VIDEO    = 480;
    localparam int SQ_WIDTH   = 16;
    localparam int PDL_WIDTH  = 12;
    localparam int PDL_HEIGHT = 96;
    localparam int NET_X      = 318;
    localparam int NET_W      = 4;
    localparam int SCORE_Y    = 24;

    localparam logic [11:0] COL_BG  = 12'h000;
    localparam logic [11:0] COL_SQ  = 12'hFF0;
    localparam logic [11:0] COL_FG  = 12'hFFF;
    localparam logic [11:0] COL_NET = 12'h888;

    localparam int DIG_W = 20;
    localparam int DIG_H = 36;
    localparam int SEG_T = 4;

    localparam logic [9:0] DIG_X_P1_TENS = 10'd248;
    localparam logic [9:0] DIG_X_P1_ONES = 10'd272;
    localparam logic [9:0] DIG_X_P2_TENS = 10'd344;
    localparam logic [9:0] DIG_X_P2_ONES = 10'd368;
    localparam logic [3:0][9:0] DIG_X_ORG =
        {DIG_X_P2_ONES, DIG_X_P2_TENS, DIG_X_P1_ONES, DIG_X_P1_TENS};

    // Segment bit order {a,b,c,d,e,f,g}; element n is the pattern for digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011,
        7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

    typedef struct packed {
        logic [9:0] sq_x;
        logic [9:0] sq_y;
        logic [9:0] p1_x;
        logic [9:0] p1_y;
        logic [9:0] p2_x;
        logic [9:0] p2_y;
        logic       sq_shown;
        logic       game_over;
        logic       game_startup;
        logic [3:0] score_p1;
        logic [3:0] score_p2;
    } game_state_t;

    localparam game_state_t STATE_RESET = '{
        sq_x: 10'd0, sq_y: 10'd0, p1_x: 10'd0, p1_y: 10'd0,
        p2_x: 10'd0, p2_y: 10'd0, sq_shown: 1'b0, game_over: 1'b0,
        game_startup: 1'b1, score_p1: 4'd0, score_p2: 4'd0
    };

    // Half-open span test done in 11 bits so org+len never wraps.
    function automatic logic in_span(input logic [9:0] p, input logic [9:0] org,
                                     input logic [10:0] len);
        return ({1'b0, p} >= {1'b0, org}) && ({1'b0, p} < ({1'b0, org} + len));
    endfunction

    function automatic logic [3:0] score_tens(input logic [3:0] s);
        return (s >= 4'd10) ? 4'd1 : 4'd0;
    endfunction

    function automatic logic [3:0] score_ones(input logic [3:0] s);
        return (s >= 4'd10) ? (s - 4'd10) : s;
    endfunction

endpackage

// File: rtl/pong_renderer_if.sv
// Game-state bundle from the game logic to the renderer: sprite corners,
// scores and state flags.
interface pong_renderer_if;

    logic [9:0] sq_xpos;
    logic [9:0] sq_ypos;
    logic [9:0] pdl1_xpos;
    logic [9:0] pdl1_ypos;
    logic [9:0] pdl2_xpos;
    logic [9:0] pdl2_ypos;
    logic       sq_shown;
    logic       game_over;
    logic       game_startup;
    logic [3:0] score_p1;
    logic [3:0] score_p2;

    modport master (
        output sq_xpos, sq_ypos, pdl1_xpos, pdl1_ypos, pdl2_xpos, pdl2_ypos,
        output sq_shown, game_over, game_startup, score_p1, score_p2
    );

    modport slave (
        input sq_xpos, sq_ypos, pdl1_xpos, pdl1_ypos, pdl2_xpos, pdl2_ypos,
        input sq_shown, game_over, game_startup, score_p1, score_p2
    );

endinterface

// File: rtl/pong_renderer_seg7_glyph.sv
// One 20x36 seven-segment score glyph: given a pixel offset inside the glyph
// box, reports whether that pixel lies on a lit segment.
module seg7_glyph
    import pong_pkg::*;
(
    input  logic [4:0] loc_x,
    input  logic [5:0] loc_y,
    input  logic [3:0] digit,
    input  logic       blank,
    output logic       lit
);

    logic [6:0] segs;
    logic       in_x, in_y;
    logic       col_l, col_r;
    logic       row_top, row_mid, row_bot, half_up, half_lo;

    always_comb begin
        segs    = (digit <= 4'd9) ? SEG_TABLE[digit] : 7'b0000000;
        in_x    = loc_x < 5'(DIG_W);
        in_y    = loc_y < 6'(DIG_H);
        col_l   = loc_x < 5'(SEG_T);
        col_r   = loc_x >= 5'(DIG_W - SEG_T);
        row_top = loc_y < 6'(SEG_T);
        // Middle bar sits at rows 16-19; upper and lower verticals overlap it.
        row_mid = (loc_y >= 6'(DIG_H / 2 - 2)) && (loc_y < 6'(DIG_H / 2 + 2));
        row_bot = loc_y >= 6'(DIG_H - SEG_T);
        half_up = loc_y < 6'(DIG_H / 2 + 2);
        half_lo = loc_y >= 6'(DIG_H / 2 - 2);

        lit = !blank && in_x && in_y &&
              ((segs[6] && row_top)           ||
               (segs[5] && col_r && half_up)  ||
               (segs[4] && col_r && half_lo)  ||
               (segs[3] && row_bot)           ||
               (segs[2] && col_l && half_lo)  ||
               (segs[1] && col_l && half_up)  ||
               (segs[0] && row_mid));
    end

endmodule

// File: rtl/pong_renderer.sv
// Per-pixel RGB generator for pong: frame-latched game state, hit detection in
// stage 1, colour priority mux in stage 2, syncs delayed to match.
module pong_renderer
    import pong_pkg::*;
(
    input  logic           clk_0,
    input  logic           rst,
    input  logic [9:0]     pix_x,
    input  logic [9:0]     pix_y,
    input  logic           video_on,
    input  logic           hsync_in,
    input  logic           vsync_in,
    input  logic           frame_start,
    pong_renderer_if.slave gs,
    output logic [11:0]    rgb,
    output logic           hsync_out,
    output logic           vsync_out
);

    game_state_t live, shadow;
    logic [5:0]  frame_cnt;

    always_comb begin
        live              = STATE_RESET;
        live.sq_x         = gs.sq_xpos;
        live.sq_y         = gs.sq_ypos;
        live.p1_x         = gs.pdl1_xpos;
        live.p1_y         = gs.pdl1_ypos;
        live.p2_x         = gs.pdl2_xpos;
        live.p2_y         = gs.pdl2_ypos;
        live.sq_shown     = gs.sq_shown;
        live.game_over    = gs.game_over;
        live.game_startup = gs.game_startup;
        live.score_p1     = gs.score_p1;
        live.score_p2     = gs.score_p2;
    end

    // A pixel coinciding with frame_start still sees the previous shadows.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            shadow    <= STATE_RESET;
            frame_cnt <= 6'd0;
        end else if (frame_start) begin
            shadow    <= live;
            frame_cnt <= frame_cnt + 6'd1;
        end
    end

    logic           on_screen, blink_on;
    logic           sq_hit, pdl_hit, net_hit, dig_hit;
    logic [3:0][3:0] dig_val;
    logic [3:0]     dig_blank;
    logic [3:0]     dig_lit;

    always_comb begin
        on_screen = (pix_x < 10'(H_VIDEO)) && (pix_y < 10'(V_VIDEO));
        sq_hit    = shadow.sq_shown &&
                    in_span(pix_x, shadow.sq_x, 11'(SQ_WIDTH)) &&
                    in_span(pix_y, shadow.sq_y, 11'(SQ_WIDTH));
        pdl_hit   = (in_span(pix_x, shadow.p1_x, 11'(PDL_WIDTH)) &&
                     in_span(pix_y, shadow.p1_y, 11'(PDL_HEIGHT))) ||
                    (in_span(pix_x, shadow.p2_x, 11'(PDL_WIDTH)) &&
                     in_span(pix_y, shadow.p2_y, 11'(PDL_HEIGHT)));
        net_hit   = in_span(pix_x, 10'(NET_X), 11'(NET_W)) && !pix_y[4];
        blink_on  = !(shadow.game_startup || shadow.game_over) || !frame_cnt[5];
    end

    always_comb begin
        dig_val[0]   = score_tens(shadow.score_p1);
        dig_val[1]   = score_ones(shadow.score_p1);
        dig_val[2]   = score_tens(shadow.score_p2);
        dig_val[3]   = score_ones(shadow.score_p2);
        dig_blank[0] = shadow.score_p1 < 4'd10;
        dig_blank[1] = 1'b0;
        dig_blank[2] = shadow.score_p2 < 4'd10;
        dig_blank[3] = 1'b0;
    end

    for (genvar i = 0; i < 4; i++) begin : g_digit
        logic       in_box;
        logic [4:0] off_x;
        logic [5:0] off_y;

        always_comb begin
            in_box = in_span(pix_x, DIG_X_ORG[i], 11'(DIG_W)) &&
                     in_span(pix_y, 10'(SCORE_Y), 11'(DIG_H));
            off_x  = 5'(pix_x - DIG_X_ORG[i]);
            off_y  = 6'(pix_y - 10'(SCORE_Y));
        end

        seg7_glyph u_glyph (
            .loc_x (off_x),
            .loc_y (off_y),
            .digit (dig_val[i]),
            .blank (dig_blank[i] || !in_box || !blink_on),
            .lit   (dig_lit[i])
        );
    end

    assign dig_hit = |dig_lit;

    function automatic logic [11:0] pick_colour(input logic vld, input logic sq,
                                                input logic pdl, input logic dig,
                                                input logic net);
        if (!vld)     return COL_BG;
        else if (sq)  return COL_SQ;
        else if (pdl) return COL_FG;
        else if (dig) return COL_FG;
        else if (net) return COL_NET;
        else          return COL_BG;
    endfunction

    // Stage 1: registered hit flags, blanking and syncs.
    logic vld_p1, sq_hit_p1, pdl_hit_p1, dig_hit_p1, net_hit_p1, hs_p1, vs_p1;

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            sq_hit_p1  <= 1'b0;
            pdl_hit_p1 <= 1'b0;
            dig_hit_p1 <= 1'b0;
            net_hit_p1 <= 1'b0;
            hs_p1      <= 1'b0;
            vs_p1      <= 1'b0;
        end else begin
            vld_p1     <= video_on && on_screen;
            sq_hit_p1  <= sq_hit;
            pdl_hit_p1 <= pdl_hit;
            dig_hit_p1 <= dig_hit;
            net_hit_p1 <= net_hit;
            hs_p1      <= hsync_in;
            vs_p1      <= vsync_in;
        end
    end

    // Stage 2: colour priority mux.
    logic [11:0] rgb_p2;
    logic        hs_p2, vs_p2;

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            rgb_p2 <= COL_BG;
            hs_p2  <= 1'b0;
            vs_p2  <= 1'b0;
        end else begin
            rgb_p2 <= pick_colour(vld_p1, sq_hit_p1, pdl_hit_p1, dig_hit_p1, net_hit_p1);
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
        end
    end

    assign rgb       = rgb_p2;
    assign hsync_out = hs_p2;
    assign vsync_out = vs_p2;

endmodule

// File: doc/pong_renderer.md
# pong_renderer

Consumer side of the game-state interface: takes the sprite coordinates, scores and state flags produced by the game logic, plus the pixel coordinates from the VGA timing generator, and produces the per-pixel RGB stream. Game state is sampled once per frame into shadow registers, so a frame never shows a sprite mid-update. Output is a registered two-stage pipeline, with syncs delayed to match. Sits between game logic and the VGA output pins.

## Interface
- H_VIDEO, 640, active pixels per line
- V_VIDEO, 480, active lines
- SQ_WIDTH, 16, square side length
- PDL_WIDTH, 12, paddle thickness
- PDL_HEIGHT, 96, paddle height
- NET_X, 318, left column of the centre net (net is 4 px wide)
- SCORE_Y, 24, top row of the score digits
- clk_0  in  1  25.175 MHz pixel clock
- rst  in  1  asynchronous, active-low reset
- pix_x, pix_y  in  10 each  current pixel coordinate
- video_on, hsync_in, vsync_in  in  1 each  from timing generator
- frame_start  in  1  one-cycle pulse, first blanking cycle of line V_VIDEO
- sq_xpos, sq_ypos, pdl1_xpos, pdl1_ypos, pdl2_xpos, pdl2_ypos  in  10 each  sprite top-left corners
- sq_shown, game_over, game_startup  in  1 each  game state flags
- score_p1, score_p2  in  4 each  scores
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}
- hsync_out, vsync_out  out  1 each  syncs aligned to rgb

## Operation
- Shadow latch: on frame_start, copy all sprite, score and flag inputs into shadow registers. Between pulses, shadows hold. All drawing uses shadows only.
- frame_cnt (6 bit): increments on each frame_start and wraps 63->0.
- Stage 1 registers the hit flags. Containment is half-open: x <= pix_x < x+W, and likewise for y.
  - sq_hit: inside the square, gated by shadow sq_shown.
  - p1_hit, p2_hit: inside the PDL_WIDTH x PDL_HEIGHT box of each paddle.
  - net_hit: NET_X <= pix_x < NET_X+4 and pix_y[4]==0, i.e. dashes 16 on, 16 off.
  - dig_hit: any lit segment of the four score digits.
- Digits: 20x36 seven-segment glyph, segment thickness 4.
  - Segments (cols, rows inclusive): a = 0-19, 0-3; b = 16-19, 0-19; c = 16-19, 16-35; d = 0-19, 32-35; e = 0-3, 16-35; f = 0-3, 0-19; g = 0-19, 16-19.
  - Digit x origins: P1 tens 248, P1 ones 272, P2 tens 344, P2 ones 368; all at SCORE_Y.
  - tens = score/10, ones = score%10, valid over the range 0-15.
  - The tens digit is blank when score < 10.
- Blink: digits are drawn only if !(game_startup|game_over), or if frame_cnt[5]==0.
- Stage 2 priority mux, highest first:
  - !video_on: 0x000
  - sq_hit: 0xFF0
  - p1_hit or p2_hit: 0xFFF
  - dig_hit: 0xFFF
  - net_hit: 0x888
  - otherwise: 0x000
- Sprites whose box extends past the screen edge are simply clipped. No wraparound in the compare: use 11-bit sums.

## Timing
- Latency is 2 cycles: pix_x/pix_y/video_on at cycle n produce rgb at n+2. hsync/vsync pass through a 2-deep delay line.
- frame_start and a pixel on the same cycle: that pixel uses the old shadows. Shadows update at the clock edge ending that cycle.
- Reset values:
  - rgb=0, hsync_out=0, vsync_out=0.
  - All pipeline stages cleared.
  - Shadow positions 0, sq_shown=0, scores 0, game_startup=1, game_over=0.
  - frame_cnt=0.
- Reset mid-frame: outputs go to reset values immediately (asynchronous). The first shadow latch happens on the next frame_start after release. Until then, only paddles at (0,0), net and blinking digits "0" are drawn.

## Structure
- Package pong_pkg holds:
  - Colour constants: COL_BG, COL_SQ, COL_FG, COL_NET.
  - Glyph geometry: DIG_W=20, DIG_H=36, SEG_T=4.
  - The digit x-origin constants.
  - The 7-bit segment table for digits 0-9.
- One sub-module, seg7_glyph: inputs local x/y offset and a 4-bit digit plus blank; output is the lit flag. Instantiated four times. Combinational, feeding the stage-1 register.

## Test plan
- Reset, then frame_start with sq=(320,240), sq_shown=1 → rgb at pixel (320,240) = 0xFFF... no: 0xFF0, appearing 2 cycles after the pixel; pixel (336,240) = 0x000.
- Change sq_xpos to 100 mid-frame with no frame_start → the square is still drawn at x=320 until the next frame_start.
- pdl1=(24,192), sq=(30,200) → pixel (30,200) = 0xFF0 (square over paddle); pixel (24,192) = 0xFFF; pixel (36,192) = 0x000.
- score_p1=10, score_p2=7 → P1 tens "1" lights pixel (265,25) (segment b); P2 tens column at 344-363 is all background; P2 ones shows "7".
- game_over=1 → digits visible for frame_cnt 0-31, hidden for 32-63, and visible again after the wrap.
- Net: pixel (319,5) = 0x888, (319,20) = 0x000; video_on=0 anywhere → 0x000; hsync_out equals hsync_in delayed by exactly 2.
